// File: rtl/heichips25_pkg.sv
// Purpose: shared types and widths for the heichips25 UART receive front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package heichips25_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_e;

endpackage

// File: rtl/heichips25_sync_fifo.sv
// Purpose: small synchronous FIFO with a flop-based head output.
// Latency: a pushed entry is visible at head/!empty the cycle after the push edge.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
// Ports: clk, rst_n (sync, active low); push/push_data write side; pop read side;
//        full, empty, count status; head = oldest entry (0 after reset).
module heichips25_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic [WIDTH-1:0]           head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem[rd_ptr];

   // A pop frees the slot the push lands in, so full+push+pop is legal.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/heichips25_uart_rx.sv
// Purpose: 8N1 UART receiver with 2-FF input sync, mid-bit sampling and a receive FIFO.
// Latency: m_valid_o rises the cycle after the stop-bit sample edge (~2 sync + 9.5 bit times).
// Backpressure: m_ready_i pops the FIFO; a byte arriving while full (no pop) is dropped, overrun_o set.
// Ports: clk, rst_n (sync, active low); rx_i serial in (idle high);
//        m_data_o/m_valid_o/m_ready_i byte stream out; frame_err_o pulse; overrun_o sticky,
//        cleared by err_clr_i; busy_o while a frame is in progress.
module heichips25_uart_rx
   import heichips25_pkg::*;
#(
   parameter int BAUD_DIV   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rx_i,
   output logic [UART_DATA_W-1:0] m_data_o,
   output logic                   m_valid_o,
   input  logic                   m_ready_i,
   output logic                   frame_err_o,
   output logic                   overrun_o,
   input  logic                   err_clr_i,
   output logic                   busy_o
);

   localparam int CNT_W = $clog2(BAUD_DIV);
   localparam int IDX_W = $clog2(UART_DATA_W);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_W - 1);

   uart_state_e            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic                   rx_meta, rx_s, rx_prev;
   logic                   push, pop, frame_err_d, frame_err_q, overrun_q;
   logic                   fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

   // Synchroniser plus edge-detect history; all reset to the idle (high) level
   // so a reset never manufactures a start edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= CNT_FULL;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            // Half-bit load lands every later sample at mid-bit.
            if (rx_prev && !rx_s) begin
               state_d = START;
               cnt_d   = CNT_HALF;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               if (!rx_s) begin
                  state_d   = DATA;
                  cnt_d     = CNT_FULL;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               shift_d   = {rx_s, shift_q[UART_DATA_W-1:1]};
               cnt_d     = CNT_FULL;
               bit_idx_d = bit_idx_q + IDX_W'(1);
               if (bit_idx_q == IDX_LAST) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (cnt_q == '0) begin
               if (rx_s) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end
         end
         BREAK: begin
            // Only a return to idle re-arms start detection.
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pop = m_valid_o & m_ready_i;

   // Set wins over clear so a drop in the clearing cycle is never lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (push && fifo_full && !pop) begin
         overrun_q <= 1'b1;
      end else if (err_clr_i) begin
         overrun_q <= 1'b0;
      end
   end

   heichips25_sync_fifo #(
      .WIDTH (UART_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (shift_q),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count_unused),
      .head      (m_data_o)
   );

   assign m_valid_o   = ~fifo_empty;
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_heichips25_uart_rx.sv
// Purpose: directed self-checking bench for heichips25_uart_rx (BAUD_DIV=16, FIFO_DEPTH=4).
// Latency: n/a.
// Backpressure: bench drives m_ready_i explicitly per step.
module tb_heichips25_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_i;
   logic [7:0] m_data_o;
   logic       m_valid_o;
   logic       m_ready_i;
   logic       frame_err_o;
   logic       overrun_o;
   logic       err_clr_i;
   logic       busy_o;

   int n_cmp = 0;
   int n_bad = 0;
   int valid_cycles = 0;
   int ferr_cycles  = 0;
   logic [7:0] cap [$];

   heichips25_uart_rx #(
      .BAUD_DIV   (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_i        (rx_i),
      .m_data_o    (m_data_o),
      .m_valid_o   (m_valid_o),
      .m_ready_i   (m_ready_i),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .err_clr_i   (err_clr_i),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   // Observe on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (m_valid_o) valid_cycles++;
      if (frame_err_o) ferr_cycles++;
      if (m_valid_o && m_ready_i) cap.push_back(m_data_o);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // mode 0: plain frame; 1: m_ready_i high for the stop-sample cycle;
   // 2: err_clr_i high for the stop-sample cycle. Stop sample edge is
   // 11 edges into the stop bit (2 sync + half-bit offset).
   task automatic send(input logic [7:0] d, input logic stop, input int mode);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         rx_i = fr[b];
         if (b == 9 && mode != 0) begin
            tick(10);
            if (mode == 1) m_ready_i = 1'b1;
            else           err_clr_i = 1'b1;
            tick(1);
            m_ready_i = 1'b0;
            err_clr_i = 1'b0;
            tick(5);
         end else begin
            tick(16);
         end
      end
      rx_i = 1'b1;
   endtask

   task automatic drain(input int n);
      cap.delete();
      m_ready_i = 1'b1;
      tick(n);
      m_ready_i = 1'b0;
   endtask

   function automatic logic [31:0] cap_at(input int i);
      return (i < cap.size()) ? {24'h0, cap[i]} : 32'hDEAD;
   endfunction

   initial begin
      int v0;
      int f0;
      logic [9:0] fr;

      rst_n = 1'b0; rx_i = 1'b1; m_ready_i = 1'b0; err_clr_i = 1'b0;
      tick(3);
      chk("rst_valid", m_valid_o, 0);
      chk("rst_data", m_data_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ovr", overrun_o, 0);
      chk("rst_ferr", frame_err_o, 0);
      rst_n = 1'b1;
      tick(3);

      // 1: single byte, consumer always ready
      m_ready_i = 1'b1; cap.delete(); v0 = valid_cycles; f0 = ferr_cycles;
      send(8'hA5, 1'b1, 0);
      tick(4);
      chk("t1_count", cap.size(), 1);
      chk("t1_byte", cap_at(0), 32'hA5);
      chk("t1_valid_cycles", valid_cycles - v0, 1);
      chk("t1_ferr", ferr_cycles - f0, 0);
      chk("t1_ovr", overrun_o, 0);
      chk("t1_busy", busy_o, 0);
      m_ready_i = 1'b0;

      // 2: 5-cycle low glitch
      v0 = valid_cycles; f0 = ferr_cycles;
      rx_i = 1'b0;
      tick(4);
      chk("t2_busy_mid", busy_o, 1);
      tick(1);
      rx_i = 1'b1;
      tick(20);
      chk("t2_busy_end", busy_o, 0);
      chk("t2_valid", m_valid_o, 0);
      chk("t2_valid_cycles", valid_cycles - v0, 0);
      chk("t2_ferr", ferr_cycles - f0, 0);

      // 3: framing error then long break
      f0 = ferr_cycles;
      send(8'h3C, 1'b0, 0);
      rx_i = 1'b0;
      chk("t3_ferr_pulse", ferr_cycles - f0, 1);
      chk("t3_busy_break", busy_o, 1);
      chk("t3_no_push", m_valid_o, 0);
      tick(640);
      chk("t3_busy_held", busy_o, 1);
      chk("t3_ferr_once", ferr_cycles - f0, 1);
      chk("t3_no_push_held", m_valid_o, 0);
      rx_i = 1'b1;
      tick(4);
      chk("t3_idle", busy_o, 0);

      // 4: overflow with consumer stalled
      f0 = ferr_cycles;
      for (int v = 1; v <= 5; v++) send(8'(v), 1'b1, 0);
      tick(2);
      chk("t4_ovr", overrun_o, 1);
      chk("t4_valid", m_valid_o, 1);
      chk("t4_head", m_data_o, 32'h01);
      chk("t4_ferr", ferr_cycles - f0, 0);
      drain(4);
      chk("t4_drain_n", cap.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t4_drain%0d", i), cap_at(i), i + 1);
      chk("t4_empty", m_valid_o, 0);
      err_clr_i = 1'b1; tick(1); err_clr_i = 1'b0;
      chk("t4_clr", overrun_o, 0);

      // 5a: full FIFO, pop coincides with 5th stop sample
      for (int v = 8'h11; v <= 8'h14; v++) send(8'(v), 1'b1, 0);
      cap.delete();
      send(8'h15, 1'b1, 1);
      chk("t5a_pop_n", cap.size(), 1);
      chk("t5a_pop", cap_at(0), 32'h11);
      chk("t5a_ovr", overrun_o, 0);
      drain(5);
      chk("t5a_drain_n", cap.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t5a_drain%0d", i), cap_at(i), 32'h12 + i);
      chk("t5a_empty", m_valid_o, 0);

      // 5b: clear requested in the cycle overrun is set
      for (int v = 8'h21; v <= 8'h24; v++) send(8'(v), 1'b1, 0);
      send(8'h25, 1'b1, 2);
      chk("t5b_ovr_wins", overrun_o, 1);
      drain(5);
      chk("t5b_drain_n", cap.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t5b_drain%0d", i), cap_at(i), 32'h21 + i);
      err_clr_i = 1'b1; tick(1); err_clr_i = 1'b0;
      chk("t5b_clr", overrun_o, 0);

      // 6: reset in the middle of data bit 4
      send(8'h77, 1'b1, 0);
      tick(2);
      chk("t6_pre_valid", m_valid_o, 1);
      chk("t6_pre_head", m_data_o, 32'h77);
      fr = {1'b1, 8'h5A, 1'b0};
      for (int b = 0; b < 5; b++) begin
         rx_i = fr[b];
         tick(16);
      end
      rx_i = fr[5];
      tick(8);
      chk("t6_busy_data", busy_o, 1);
      rst_n = 1'b0; rx_i = 1'b1;
      tick(1);
      chk("t6_rst_busy", busy_o, 0);
      chk("t6_rst_valid", m_valid_o, 0);
      chk("t6_rst_data", m_data_o, 0);
      rst_n = 1'b1;
      tick(3);
      m_ready_i = 1'b1; cap.delete();
      send(8'h5A, 1'b1, 0);
      tick(3);
      m_ready_i = 1'b0;
      chk("t6_after_n", cap.size(), 1);
      chk("t6_after", cap_at(0), 32'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
